// File: rtl/gpi_debounce_core_if.sv
// Slot bus between the MMIO decoder and a peripheral core.
// The master drives address/strobes/write data; the slave returns combinational read data.
interface gpi_debounce_core_if;
  logic [4:0]  address;
  logic [31:0] rd_data;
  logic [31:0] wr_data;
  logic        read;
  logic        write;
  logic        cs;

  modport master (
    output address, wr_data, read, write, cs,
    input  rd_data
  );

  modport slave (
    input  address, wr_data, read, write, cs,
    output rd_data
  );
endinterface

// File: rtl/gpi_debounce_core.sv
// Debounced GPI core: per-pin 2-flop synchroniser, stable-count debounce,
// sticky W1C rise/fall edge flags and a level interrupt.
module gpi_debounce_core #(
  parameter int WIDTH    = 16,
  parameter int DB_LIMIT = 20000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gpi_debounce_core_if.slave   bus,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 irq
);

  localparam int CW = (DB_LIMIT > 1) ? $clog2(DB_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_LIMIT - 1);

  localparam logic [4:0] ADDR_DATA = 5'h00;
  localparam logic [4:0] ADDR_RISE = 5'h01;
  localparam logic [4:0] ADDR_FALL = 5'h02;
  localparam logic [4:0] ADDR_CTRL = 5'h03;
  localparam logic [4:0] ADDR_RAW  = 5'h04;

  typedef struct packed {
    logic irq_en;
    logic cap_en;
    logic db_en;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{irq_en: 1'b0, cap_en: 1'b1, db_en: 1'b1};

  logic [WIDTH-1:0] s1, s2, db, rise, fall;
  logic [CW-1:0]    cnt [WIDTH];
  ctrl_t            ctrl;

  logic [WIDTH-1:0] db_nxt, rise_nxt, fall_nxt;
  logic [WIDTH-1:0] rise_clr, fall_clr;
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic             wr_en;

  // Per-bit debounce: a bit must disagree with db for DB_LIMIT consecutive
  // samples before it is accepted; any agreement restarts the count.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, otherwise an unassigned path infers a latch.
    db_nxt = db;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (!ctrl.db_en) begin
        db_nxt[i] = s2[i];
      end else if (s2[i] != db[i]) begin
        if (cnt[i] == CNT_LAST) db_nxt[i] = s2[i];
        else                    cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  assign wr_en    = bus.cs & bus.write;
  assign rise_clr = (wr_en && bus.address == ADDR_RISE) ? bus.wr_data[WIDTH-1:0] : '0;
  assign fall_clr = (wr_en && bus.address == ADDR_FALL) ? bus.wr_data[WIDTH-1:0] : '0;

  // Set is OR-ed after the clear so a same-cycle set beats a W1C.
  assign rise_nxt = (rise & ~rise_clr) | (ctrl.cap_en ? (db_nxt & ~db) : '0);
  assign fall_nxt = (fall & ~fall_clr) | (ctrl.cap_en ? (~db_nxt & db) : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      rise <= '0;
      fall <= '0;
      ctrl <= CTRL_RESET;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      s1   <= data_in;
      s2   <= s1;
      db   <= db_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
      if (wr_en && bus.address == ADDR_CTRL) ctrl <= ctrl_t'(bus.wr_data[2:0]);
    end
  end

  always_comb begin
    bus.rd_data = '0;
    case (bus.address)
      ADDR_DATA: bus.rd_data[WIDTH-1:0] = db;
      ADDR_RISE: bus.rd_data[WIDTH-1:0] = rise;
      ADDR_FALL: bus.rd_data[WIDTH-1:0] = fall;
      ADDR_CTRL: bus.rd_data[2:0]       = ctrl;
      ADDR_RAW:  bus.rd_data[WIDTH-1:0] = s2;
      default:   bus.rd_data            = '0;
    endcase
  end

  assign irq = ctrl.irq_en & (|rise | |fall);

  // Reads have no side effects, and upper write-data bits beyond WIDTH are ignored.
  logic unused_bus;
  assign unused_bus = &{1'b0, bus.read, bus.wr_data};

endmodule

// File: tb/tb_gpi_debounce_core.sv
// Self-checking bench for gpi_debounce_core: directed scenarios plus a random
// phase, compared against a sample-window reference model.
module tb_gpi_debounce_core;

  localparam int W  = 16;
  localparam int DB = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic         irq;

  gpi_debounce_core_if bus();

  gpi_debounce_core #(.WIDTH(W), .DB_LIMIT(DB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .data_in (data_in),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a level is accepted once the last DB synchronised
  // samples all disagree with the current debounced level.
  logic [W-1:0]  m_s1, m_s2, m_db, m_rise, m_fall;
  logic [2:0]    m_ctrl;
  logic [DB-1:0] m_hist [W];
  logic [W-1:0]  md_s2_pre, md_db_new, md_rclr, md_fclr;
  logic [2:0]    md_ctrl_pre;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
      m_ctrl = 3'b011;
      for (int i = 0; i < W; i++) m_hist[i] = '0;
    end else begin
      md_s2_pre   = m_s2;
      md_ctrl_pre = m_ctrl;
      m_s2 = m_s1;
      m_s1 = data_in;
      for (int i = 0; i < W; i++) begin
        m_hist[i] = {m_hist[i][DB-2:0], md_s2_pre[i]};
        if (!md_ctrl_pre[0])                      md_db_new[i] = md_s2_pre[i];
        else if (m_hist[i] == {DB{~m_db[i]}})     md_db_new[i] = ~m_db[i];
        else                                      md_db_new[i] = m_db[i];
      end
      md_rclr = '0;
      md_fclr = '0;
      if (bus.cs && bus.write) begin
        case (bus.address)
          5'h01:   md_rclr = bus.wr_data[W-1:0];
          5'h02:   md_fclr = bus.wr_data[W-1:0];
          5'h03:   m_ctrl  = bus.wr_data[2:0];
          default: ;
        endcase
      end
      m_rise = (m_rise & ~md_rclr) | (md_ctrl_pre[1] ? (md_db_new & ~m_db) : '0);
      m_fall = (m_fall & ~md_fclr) | (md_ctrl_pre[1] ? (~md_db_new & m_db) : '0);
      m_db   = md_db_new;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    case (a)
      5'h00:   return 32'(m_db);
      5'h01:   return 32'(m_rise);
      5'h02:   return 32'(m_fall);
      5'h03:   return 32'(m_ctrl);
      5'h04:   return 32'(m_s2);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_irq();
    return m_ctrl[2] & (|m_rise | |m_fall);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic rd_exp(input string tag, input logic [4:0] a, input logic [31:0] v);
    bus.address = a;
    #1;
    check(tag, bus.rd_data, v);
  endtask

  task automatic rd_mdl(input string tag, input logic [4:0] a);
    bus.address = a;
    #1;
    check(tag, bus.rd_data, exp_rd(a));
    check({tag, "_irq"}, {31'b0, irq}, {31'b0, exp_irq()});
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic c = 1'b1);
    bus.cs = c; bus.write = 1'b1; bus.address = a; bus.wr_data = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    rd_exp({tag, "_data"}, 5'h00, 32'h0);
    rd_exp({tag, "_rise"}, 5'h01, 32'h0);
    rd_exp({tag, "_fall"}, 5'h02, 32'h0);
    rd_exp({tag, "_ctrl"}, 5'h03, 32'h3);
    rd_exp({tag, "_raw"},  5'h04, 32'h0);
    check({tag, "_irq"}, {31'b0, irq}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_rise;
    bus.cs = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    bus.address = '0; bus.wr_data = '0; data_in = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) cyc();
    check_reset_state("por");
    rst_n = 1'b1;
    cyc();

    // Clean press on bit 3: RAW after k+1, DATA and RISE after k+DB+1.
    data_in[3] = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      cyc();
      rd_exp("press_raw",  5'h04, (j >= 1) ? 32'h8 : 32'h0);
      rd_exp("press_data", 5'h00, (j >= 9) ? 32'h8 : 32'h0);
      rd_exp("press_rise", 5'h01, (j >= 9) ? 32'h8 : 32'h0);
    end
    bus_write(5'h01, 32'h8);
    rd_exp("press_rise_clr", 5'h01, 32'h0);

    // Bounce on bit 0 with 3-cycle runs, then settle high.
    for (int t = 0; t < 40; t++) begin
      data_in[0] = ((t / 3) % 2 == 0);
      cyc();
      rd_exp("bounce_data", 5'h00, 32'h8);
      rd_mdl("bounce_mdl", 5'h01);
    end
    data_in[0] = 1'b1;
    first_rise = -1;
    for (int j = 0; j < 20; j++) begin
      cyc();
      bus.address = 5'h01;
      #1;
      if (first_rise < 0 && bus.rd_data[0]) first_rise = j;
    end
    check("bounce_rise_latency", 32'(first_rise), 32'd9);
    rd_exp("bounce_rise", 5'h01, 32'h1);
    rd_exp("bounce_fall", 5'h02, 32'h0);
    bus_write(5'h01, 32'h1);

    // Release, clear FALL, then W1C RISE on the very edge db[0] rises.
    data_in[0] = 1'b0;
    repeat (12) cyc();
    bus_write(5'h02, 32'h1);
    rd_exp("coll_fall_clr", 5'h02, 32'h0);
    data_in[0] = 1'b1;
    repeat (9) cyc();
    rd_exp("coll_pre_data", 5'h00, 32'h8);
    bus_write(5'h01, 32'h1);
    rd_exp("coll_rise", 5'h01, 32'h1);
    bus_write(5'h03, 32'h7);
    data_in[0] = 1'b0;
    repeat (12) cyc();
    rd_exp("coll_fall", 5'h02, 32'h1);
    check("coll_irq_on", {31'b0, irq}, 32'h1);
    bus_write(5'h01, 32'h1);
    bus_write(5'h02, 32'h1);
    check("coll_irq_off", {31'b0, irq}, 32'h0);

    // Bypass with capture disabled: DATA follows after 2 edges, no flags.
    bus_write(5'h03, 32'h0);
    data_in[5] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cyc();
      rd_exp("byp_up_data", 5'h00, (j >= 2) ? 32'h28 : 32'h8);
      rd_exp("byp_up_rise", 5'h01, 32'h0);
    end
    data_in[5] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cyc();
      rd_exp("byp_dn_data", 5'h00, (j >= 2) ? 32'h8 : 32'h28);
      rd_exp("byp_dn_fall", 5'h02, 32'h0);
    end
    bus_write(5'h03, 32'h3);
    data_in[5] = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      cyc();
      rd_exp("resume_data", 5'h00, (j >= 9) ? 32'h28 : 32'h8);
      rd_exp("resume_rise", 5'h01, (j >= 9) ? 32'h20 : 32'h0);
    end

    // Address map: unmapped reads, read-only writes, cs=0 writes.
    for (int a = 5; a < 32; a++) rd_exp("unmapped", 5'(a), 32'h0);
    bus_write(5'h00, 32'hFFFF_FFFF);
    bus_write(5'h04, 32'hFFFF_FFFF);
    rd_exp("ro_data", 5'h00, 32'h28);
    rd_exp("ro_raw",  5'h04, 32'h28);
    rd_exp("ro_ctrl", 5'h03, 32'h3);
    rd_exp("ro_rise", 5'h01, 32'h20);
    bus_write(5'h03, 32'h0, 1'b0);
    bus_write(5'h01, 32'hFFFF, 1'b0);
    rd_exp("nocs_ctrl", 5'h03, 32'h3);
    rd_exp("nocs_rise", 5'h01, 32'h20);
    rd_mdl("map_mdl", 5'h00);

    // Random pins and bus traffic against the model.
    bus_write(5'h03, 32'h7);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) data_in[$urandom_range(0, W - 1)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        bus.cs      = 1'($urandom_range(0, 1));
        bus.write   = 1'b1;
        bus.address = 5'($urandom_range(0, 7));
        bus.wr_data = $urandom;
      end
      cyc();
      bus.cs = 1'b0; bus.write = 1'b0;
      rd_mdl("rand", 5'($urandom_range(0, 7)));
    end

    // Asynchronous reset mid-debounce with a flag pending.
    bus_write(5'h03, 32'h7);
    data_in = '0;
    repeat (12) cyc();
    data_in[7] = 1'b1;
    repeat (12) cyc();
    rd_mdl("pre_rst", 5'h01);
    check("pre_rst_irq", {31'b0, irq}, 32'h1);
    data_in[7] = 1'b0;
    repeat (4) cyc();
    #10 rst_n = 1'b0;
    check_reset_state("async_rst");
    repeat (2) cyc();
    check_reset_state("hold_rst");
    rst_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      cyc();
      rd_mdl("post_rst", 5'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
